// File: rtl/led_pattern_pkg.sv
// Shared encodings and helpers for the LED pattern sequencer.
package led_pattern_pkg;

    localparam logic [1:0] MODE_CHASE  = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Mask with the n low bits set; saturates at 0 and 32 bits.
    function automatic logic [31:0] lsb_mask(input int n);
        if (n <= 0) begin
            return 32'h0000_0000;
        end
        if (n >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return 32'hFFFF_FFFF >> (32 - n);
    endfunction

    function automatic logic [31:0] start_pattern(input logic [1:0] mode, input int num_leds);
        if (mode == MODE_BLINK) begin
            return lsb_mask(num_leds);
        end
        return 32'h0000_0001;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV enabled clocks.
module tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Combinational so the consumer can act on the same edge that wraps cnt.
    assign tick = enable && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// Run-time selectable LED pattern sequencer (chase, bounce, blink, fill).
//
// state        | meaning
// -------------+--------------------------------------------------------
// DIR_UP       | bounce one-hot moves toward bit NUM_LEDS-1 on each step
// DIR_DOWN     | bounce one-hot moves toward bit 0 on each step
// mode_q       | pattern on display; only re-sampled from mode on a step
// lvl_q        | fill level, 0..NUM_LEDS lit LEDs counted from bit 0
module led_pattern_seq
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_strobe,
    output logic [1:0]          mode_active
);

    localparam int LVL_W = $clog2(NUM_LEDS + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEDS);

    logic                tick;
    dir_t                dir_q, dir_n;
    logic [LVL_W-1:0]    lvl_q, lvl_n, lvl_inc;
    logic [1:0]          mode_q, mode_n;
    logic [NUM_LEDS-1:0] leds_n, shl, shr;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign mode_active = mode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            leds        <= NUM_LEDS'(1);
            dir_q       <= DIR_UP;
            lvl_q       <= LVL_W'(1);
            mode_q      <= MODE_CHASE;
            step_strobe <= 1'b0;
        end else begin
            leds        <= leds_n;
            dir_q       <= dir_n;
            lvl_q       <= lvl_n;
            mode_q      <= mode_n;
            step_strobe <= tick;
        end
    end

    always_comb begin
        leds_n  = leds;
        dir_n   = dir_q;
        lvl_n   = lvl_q;
        mode_n  = mode_q;
        shl     = leds << 1;
        shr     = leds >> 1;
        lvl_inc = (lvl_q == LVL_MAX) ? '0 : lvl_q + 1'b1;

        if (tick) begin
            if (mode != mode_q) begin
                // A pending mode change beats advancing the old pattern.
                mode_n = mode;
                dir_n  = DIR_UP;
                lvl_n  = LVL_W'(1);
                leds_n = NUM_LEDS'(start_pattern(mode, NUM_LEDS));
            end else begin
                case (mode_q)
                    MODE_CHASE: begin
                        leds_n = shl | (leds >> (NUM_LEDS - 1));
                    end
                    MODE_BOUNCE: begin
                        // A single LED has nowhere to go, so it simply stays lit.
                        if (NUM_LEDS > 1) begin
                            if (dir_q == DIR_UP) begin
                                leds_n = shl;
                                if (shl[NUM_LEDS-1]) begin
                                    dir_n = DIR_DOWN;
                                end
                            end else begin
                                leds_n = shr;
                                if (shr[0]) begin
                                    dir_n = DIR_UP;
                                end
                            end
                        end
                    end
                    MODE_BLINK: begin
                        leds_n = ~leds;
                    end
                    default: begin
                        lvl_n  = lvl_inc;
                        leds_n = NUM_LEDS'(lsb_mask(int'(lvl_inc)));
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: a 4-LED/div-4 and a 1-LED/div-1 instance
// compared against a step-count model of the patterns.
module tb_led_pattern_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, en4 = 1'b0;
    logic [1:0] md4  = 2'b00;
    logic [3:0] leds4;
    logic       stb4;
    logic [1:0] mact4;

    logic       rst1 = 1'b1, en1 = 1'b0;
    logic [1:0] md1  = 2'b00;
    logic [0:0] leds1;
    logic       stb1;
    logic [1:0] mact1;

    led_pattern_seq #(.NUM_LEDS(4), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset(rst4), .enable(en4), .mode(md4),
        .leds(leds4), .step_strobe(stb4), .mode_active(mact4)
    );

    led_pattern_seq #(.NUM_LEDS(1), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(rst1), .enable(en1), .mode(md1),
        .leds(leds1), .step_strobe(stb1), .mode_active(mact1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: index 0 tracks dut4, index 1 tracks dut1. m_k counts steps since the
    // current pattern was started; the expected LEDs are a closed-form function of it.
    int          m_cnt [2] = '{0, 0};
    int          m_k   [2] = '{0, 0};
    int          m_mode[2] = '{0, 0};
    int          m_div [2] = '{4, 1};
    int          m_n   [2] = '{4, 1};
    logic [31:0] exp_leds[2];
    logic        exp_stb [2];
    logic [1:0]  exp_mode[2];

    function automatic logic [31:0] pattern_of(input int mode, input int k, input int n);
        int p, r, pos, lvl;
        case (mode)
            0: return 32'h1 << (k % n);
            1: begin
                if (n == 1) return 32'h1;
                p   = 2 * (n - 1);
                r   = k % p;
                pos = (r < n) ? r : p - r;
                return 32'h1 << pos;
            end
            2: return ((k % 2) == 0) ? ((32'h1 << n) - 1) : 32'h0;
            default: begin
                lvl = (1 + k) % (n + 1);
                return (32'h1 << lvl) - 1;
            end
        endcase
    endfunction

    task automatic model_edge(input int i, input logic r, input logic e, input logic [1:0] m);
        if (r) begin
            m_cnt[i] = 0; m_k[i] = 0; m_mode[i] = 0; exp_stb[i] = 1'b0;
        end else if (!e) begin
            exp_stb[i] = 1'b0;
        end else if (m_cnt[i] == m_div[i] - 1) begin
            m_cnt[i]   = 0;
            exp_stb[i] = 1'b1;
            if (int'(m) != m_mode[i]) begin
                m_mode[i] = int'(m);
                m_k[i]    = 0;
            end else begin
                m_k[i]++;
            end
        end else begin
            m_cnt[i]++;
            exp_stb[i] = 1'b0;
        end
        exp_leds[i] = pattern_of(m_mode[i], m_k[i], m_n[i]);
        exp_mode[i] = 2'(m_mode[i]);
    endtask

    // Inputs change 1 time unit after an edge; outputs are read there too.
    task automatic cycle();
        @(posedge clk);
        model_edge(0, rst4, en4, md4);
        model_edge(1, rst1, en1, md1);
        #1;
    endtask

    task automatic test_reset();
        rst4 = 1'b1; en4 = 1'b1; md4 = 2'b10;
        rst1 = 1'b1; en1 = 1'b1; md1 = 2'b11;
        cycle();
        cycle();
        n_checks++;
        if ({mact4, stb4, leds4} !== 7'b00_0_0001) begin
            n_fail++;
            $display("FAIL reset4: got mode=%0d strobe=%b leds=%b, expected mode=0 strobe=0 leds=0001",
                     mact4, stb4, leds4);
        end
        n_checks++;
        if ({mact1, stb1, leds1} !== 4'b00_0_1) begin
            n_fail++;
            $display("FAIL reset1: got mode=%0d strobe=%b leds=%b, expected mode=0 strobe=0 leds=1",
                     mact1, stb1, leds1);
        end
    endtask

    task automatic test_chase();
        rst4 = 1'b1; cycle();
        rst4 = 1'b0; en4 = 1'b1; md4 = 2'b00;
        for (int c = 0; c < 20; c++) begin
            cycle();
            n_checks++;
            if ({mact4, stb4, leds4} !== {exp_mode[0], exp_stb[0], exp_leds[0][3:0]}) begin
                n_fail++;
                $display("FAIL chase cyc%0d: got mode=%0d strobe=%b leds=%b, expected mode=%0d strobe=%b leds=%b",
                         c, mact4, stb4, leds4, exp_mode[0], exp_stb[0], exp_leds[0][3:0]);
            end
        end
    endtask

    task automatic test_bounce();
        rst4 = 1'b1; cycle();
        rst4 = 1'b0; en4 = 1'b1; md4 = 2'b01;
        for (int c = 0; c < 40; c++) begin
            cycle();
            n_checks++;
            if ({mact4, stb4, leds4} !== {exp_mode[0], exp_stb[0], exp_leds[0][3:0]}) begin
                n_fail++;
                $display("FAIL bounce cyc%0d: got mode=%0d strobe=%b leds=%b, expected mode=%0d strobe=%b leds=%b",
                         c, mact4, stb4, leds4, exp_mode[0], exp_stb[0], exp_leds[0][3:0]);
            end
        end
    endtask

    task automatic test_fill_blink();
        rst4 = 1'b1; cycle();
        rst4 = 1'b0; en4 = 1'b1; md4 = 2'b11;
        for (int c = 0; c < 46; c++) begin
            // Switch to BLINK mid-prescaler, well away from a step edge.
            if (c == 25) md4 = 2'b10;
            cycle();
            n_checks++;
            if ({mact4, stb4, leds4} !== {exp_mode[0], exp_stb[0], exp_leds[0][3:0]}) begin
                n_fail++;
                $display("FAIL fill_blink cyc%0d: got mode=%0d strobe=%b leds=%b, expected mode=%0d strobe=%b leds=%b",
                         c, mact4, stb4, leds4, exp_mode[0], exp_stb[0], exp_leds[0][3:0]);
            end
        end
    endtask

    task automatic test_freeze();
        rst4 = 1'b1; cycle();
        rst4 = 1'b0; en4 = 1'b1; md4 = 2'b00;
        for (int c = 0; c < 40 && exp_leds[0][3:0] != 4'b0100; c++) cycle();
        n_checks++;
        if (leds4 !== 4'b0100) begin
            n_fail++;
            $display("FAIL freeze_setup: got leds=%b, expected leds=0100", leds4);
        end
        cycle();
        en4 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_checks++;
            if ({mact4, stb4, leds4} !== 7'b00_0_0100) begin
                n_fail++;
                $display("FAIL freeze cyc%0d: got mode=%0d strobe=%b leds=%b, expected mode=0 strobe=0 leds=0100",
                         c, mact4, stb4, leds4);
            end
        end
        en4 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            n_checks++;
            if ({mact4, stb4, leds4} !== {exp_mode[0], exp_stb[0], exp_leds[0][3:0]}) begin
                n_fail++;
                $display("FAIL resume cyc%0d: got mode=%0d strobe=%b leds=%b, expected mode=%0d strobe=%b leds=%b",
                         c, mact4, stb4, leds4, exp_mode[0], exp_stb[0], exp_leds[0][3:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst4 = 1'b1; cycle();
        rst4 = 1'b0; en4 = 1'b1; md4 = 2'b01;
        // Step 5 of a 4-LED bounce is the downward pass through 0010.
        for (int c = 0; c < 60 && !(m_mode[0] == 1 && m_k[0] == 5); c++) cycle();
        cycle();
        n_checks++;
        if ({mact4, leds4} !== 6'b01_0010) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got mode=%0d leds=%b, expected mode=1 leds=0010", mact4, leds4);
        end
        rst4 = 1'b1;
        cycle();
        n_checks++;
        if ({mact4, stb4, leds4} !== 7'b00_0_0001) begin
            n_fail++;
            $display("FAIL reset_mid: got mode=%0d strobe=%b leds=%b, expected mode=0 strobe=0 leds=0001",
                     mact4, stb4, leds4);
        end
        rst4 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            n_checks++;
            if ({mact4, stb4, leds4} !== {exp_mode[0], exp_stb[0], exp_leds[0][3:0]}) begin
                n_fail++;
                $display("FAIL after_reset cyc%0d: got mode=%0d strobe=%b leds=%b, expected mode=%0d strobe=%b leds=%b",
                         c, mact4, stb4, leds4, exp_mode[0], exp_stb[0], exp_leds[0][3:0]);
            end
        end
    endtask

    task automatic test_single_led();
        logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        rst1 = 1'b1; cycle();
        rst1 = 1'b0; en1 = 1'b1;
        for (int s = 0; s < 5; s++) begin
            md1 = seq[s];
            for (int c = 0; c < 5; c++) begin
                if (s == 4 && c >= 2) en1 = 1'b0;
                cycle();
                n_checks++;
                if ({mact1, stb1, leds1} !== {exp_mode[1], exp_stb[1], exp_leds[1][0]}) begin
                    n_fail++;
                    $display("FAIL single s%0d c%0d: got mode=%0d strobe=%b leds=%b, expected mode=%0d strobe=%b leds=%b",
                             s, c, mact1, stb1, leds1, exp_mode[1], exp_stb[1], exp_leds[1][0]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst4 = ($urandom_range(0, 59) == 0);
            en4  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) md4 = 2'($urandom_range(0, 3));
            rst1 = ($urandom_range(0, 59) == 0);
            en1  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) md1 = 2'($urandom_range(0, 3));
            cycle();
            n_checks++;
            if ({mact4, stb4, leds4} !== {exp_mode[0], exp_stb[0], exp_leds[0][3:0]}) begin
                n_fail++;
                $display("FAIL random4 cyc%0d: got mode=%0d strobe=%b leds=%b, expected mode=%0d strobe=%b leds=%b",
                         c, mact4, stb4, leds4, exp_mode[0], exp_stb[0], exp_leds[0][3:0]);
            end
            n_checks++;
            if ({mact1, stb1, leds1} !== {exp_mode[1], exp_stb[1], exp_leds[1][0]}) begin
                n_fail++;
                $display("FAIL random1 cyc%0d: got mode=%0d strobe=%b leds=%b, expected mode=%0d strobe=%b leds=%b",
                         c, mact1, stb1, leds1, exp_mode[1], exp_stb[1], exp_leds[1][0]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_chase();
        test_bounce();
        test_fill_blink();
        test_freeze();
        test_reset_mid();
        test_single_led();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
